div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for LoongArch div.w/mod.w/div.wu/mod.wu in the EXE stage.
//  Replaces the single-cycle '/' and '%' paths with a radix-2 restoring divider.
//  The EXE stage holds its pipeline while the request is accepted and out_valid_o is low.
//  mul/ALU ops keep using the combinational ALU; only divide ops are routed here.
// PARAMETERS
//  WIDTH    32   operand/result width in bits
//  CNT_W    6    iteration counter width; must satisfy CNT_W >= $clog2(WIDTH+1)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  flush_i      in   1      synchronous kill (exception/branch flush); abandons current op
//  in_valid_i   in   1      request valid
//  in_ready_o   out  1      high only in IDLE with flush_i low
//  op_i         in   2      00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//  x_i          in   WIDTH  dividend
//  y_i          in   WIDTH  divisor
//  out_valid_o  out  1      result valid; held until accepted
//  out_ready_i  in   1      consumer accepts result
//  result_o     out  WIDTH  quotient or remainder, selected by the latched op
//  busy_o       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o=1; out_valid_o=0; busy_o=0; result_o=0; all internal regs 0.
//  Handshake: accept when in_valid_i & in_ready_o; latch op_i, x_i, y_i that edge.
//  - Result accepted when out_valid_o & out_ready_i.
//  - result_o is stable while out_valid_o=1 and not yet accepted.
//  FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: wait for handshake.
//  - PREP: signed ops take |x|, |y|; record neg_q=x[W-1]^y[W-1], neg_r=x[W-1].
//    Unsigned ops: neg_q=neg_r=0. Clear remainder; cnt=0.
//    y==0 -> skip to DONE with div-by-zero result.
//  - CALC: one iteration per cycle: rem={rem,quo[W-1]}, quo<<=1;
//    if rem>=|y| then rem-=|y| and quo[0]=1. Run exactly WIDTH cycles (cnt 0..WIDTH-1).
//  - FIX: negate quotient if neg_q, remainder if neg_r; select by op; register into result_o.
//  - DONE: out_valid_o=1; to IDLE on out_ready_i; stays in DONE otherwise.
//  Timing (handshake edge ends cycle 0):
//  - PREP is cycle 1; CALC is cycles 2..WIDTH+1; FIX is cycle WIDTH+2.
//  - out_valid_o is high from cycle WIDTH+3, i.e. cycle 35 at default WIDTH.
//  - Div-by-zero: out_valid_o is high from cycle 2.
//  Back-to-back: in_ready_o returns high the cycle after the result is accepted, never sooner.
//  Arithmetic: truncating division; remainder sign follows the dividend; all results are mod 2^WIDTH.
//  - Div-by-zero (any op): quotient = all ones; remainder = x_i unchanged.
//  - Signed overflow 0x80000000/-1: quotient 0x80000000, remainder 0 (natural result, no special case).
//  Flush:
//  - flush_i in any state -> IDLE next edge; out_valid_o=0; pending result dropped.
//  - flush_i wins over a same-cycle in_valid_i, since in_ready_o is forced low.
//  - flush_i in DONE, same cycle as out_ready_i: the accept occurs; state goes to IDLE.
//  Reset mid-operation: immediate return to reset values; no output is produced.
//  in_valid_i outside IDLE is ignored; operand inputs are don't-care after acceptance.
// TESTING
//  div.w 100/7 -> result_o=14, out_valid_o first high exactly 35 cycles after the accept.
//  mod.w -7 % 2 -> 0xFFFFFFFF; div.w -7/2 -> 0xFFFFFFFD; div.wu 0xFFFFFFFF/1 -> 0xFFFFFFFF.
//  div.w 0x80000000/0xFFFFFFFF -> 0x80000000; mod.w same operands -> 0.
//  div.wu 5/0 -> 0xFFFFFFFF at cycle 2; mod.wu 5/0 -> 5.
//  flush_i at cycle 10 of CALC -> IDLE next cycle, no out_valid_o; next request completes correctly.
//  out_ready_i low for 5 cycles in DONE -> result_o/out_valid_o held; in_ready_o stays low.
//  Random signed/unsigned operands vs. a reference model, including back-to-back ops and random out_ready_i.

Source files
------------

// File: rtl/div_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : div_seq_ctrl
// Brief    : Multi-cycle radix-2 restoring divider sequencer for the EXE stage
//            (div.w / mod.w / div.wu / mod.wu) with valid/ready handshakes,
//            synchronous flush and asynchronous active-low reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [1:0]       r_op;        // bit1: unsigned, bit0: remainder wanted
   logic [WIDTH-1:0] r_quo;       // raw dividend, then |x|, then quotient
   logic [WIDTH-1:0] r_div;       // raw divisor, then |y|
   logic [WIDTH-1:0] r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;

   logic             w_signed;
   logic             w_x_neg;
   logic             w_y_neg;
   logic [WIDTH-1:0] w_x_abs;
   logic [WIDTH-1:0] w_y_abs;
   logic             w_div_zero;
   logic [WIDTH:0]   w_rem_sh;
   logic             w_rem_ge;
   logic [WIDTH-1:0] w_rem_sub;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH-1:0] w_fix_res;
   logic             w_accept;

   // Flush forces in_ready low so a killed cycle can never start a new op
   assign in_ready_o  = (r_state == S_IDLE) && !flush_i;
   assign w_accept    = in_valid_i && in_ready_o;
   assign out_valid_o = r_out_valid;
   assign result_o    = r_result;
   assign busy_o      = (r_state != S_IDLE);

   // Operand conditioning used in PREP (r_quo/r_div still hold the raw operands)
   assign w_signed   = !r_op[1];
   assign w_x_neg    = w_signed && r_quo[WIDTH-1];
   assign w_y_neg    = w_signed && r_div[WIDTH-1];
   assign w_x_abs    = w_x_neg ? (-r_quo) : r_quo;
   assign w_y_abs    = w_y_neg ? (-r_div) : r_div;
   assign w_div_zero = (r_div == '0);

   // One restoring step: shift next dividend bit into the partial remainder;
   // the difference fits in WIDTH bits whenever the subtraction is taken
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_rem_ge  = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_div;

   // Sign fix-up: quotient sign is x^y, remainder sign follows the dividend
   assign w_quo_fix = r_neg_q ? (-r_quo) : r_quo;
   assign w_rem_fix = r_neg_r ? (-r_rem) : r_rem;
   assign w_fix_res = r_op[0] ? w_rem_fix : w_quo_fix;

   // Sequencer: IDLE -> PREP -> CALC x WIDTH -> FIX -> DONE, flush returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else if (flush_i) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= op_i;
                  r_quo   <= x_i;
                  r_div   <= y_i;
                  r_state <= S_PREP;
               end
            end
            S_PREP: begin
               r_rem   <= '0;
               r_cnt   <= '0;
               r_neg_q <= w_x_neg ^ w_y_neg;
               r_neg_r <= w_x_neg;
               if (w_div_zero) begin
                  // quotient all ones, remainder is the untouched dividend
                  r_result    <= r_op[0] ? r_quo : '1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_quo   <= w_x_abs;
                  r_div   <= w_y_abs;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_rem_ge};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST_ITER) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result    <= w_fix_res;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
